// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for port A of the program-space block RAM.
// It grants one access per clock, registers the command, and returns read data two cycles after the grant.
module mem_port_arbiter #(
   parameter int ADDR_BITS      = 14,
   parameter int DATA_WIDTH     = 16,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_BITS-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_BITS-1:0]  addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   logic                  last_gnt_reg;
   logic                  tag_read_reg;
   logic                  tag_id_reg;
   logic                  rvalid0_reg;
   logic                  rvalid1_reg;
   logic [DATA_WIDTH-1:0] rdata0_reg;
   logic [DATA_WIDTH-1:0] rdata1_reg;
   logic                  prio0;
   logic                  win_we;

   // Requester 0 wins a tie in fixed mode, or when requester 1 was served last.
   always_comb begin
      prio0  = (FIXED_PRIORITY != 0) || last_gnt_reg;
      gnt0   = reset_n && req0 && (!req1 || prio0);
      gnt1   = reset_n && req1 && !(req0 && prio0);
      win_we = gnt1 ? we1 : we0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_reg <= 1'b1;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
         tag_read_reg <= 1'b0;
         tag_id_reg   <= 1'b0;
         rvalid0_reg  <= 1'b0;
         rvalid1_reg  <= 1'b0;
         rdata0_reg   <= '0;
         rdata1_reg   <= '0;
      end else begin
         if (gnt0 || gnt1) begin
            last_gnt_reg <= gnt1;
            mem_en       <= 1'b1;
            mem_we       <= win_we;
            mem_addr     <= gnt1 ? addr1 : addr0;
            mem_din      <= gnt1 ? wdata1 : wdata0;
            tag_read_reg <= !win_we;
            tag_id_reg   <= gnt1;
         end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
         end
         // The RAM answers in the cycle after mem_en; writes never raise rvalid.
         rvalid0_reg <= mem_en && tag_read_reg && !tag_id_reg;
         rvalid1_reg <= mem_en && tag_read_reg && tag_id_reg;
         if (rvalid0_reg) rdata0_reg <= mem_dout;
         if (rvalid1_reg) rdata1_reg <= mem_dout;
      end
   end

   // Read data passes straight through in its valid cycle, then holds.
   assign rvalid0 = rvalid0_reg;
   assign rvalid1 = rvalid1_reg;
   assign rdata0  = rvalid0_reg ? mem_dout : rdata0_reg;
   assign rdata1  = rvalid1_reg ? mem_dout : rdata1_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver queues expected reads at grant time,
// and the monitor pops them when rvalid appears.
module tb_mem_port_arbiter;
   localparam int AB = 14;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [AB-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic mem_en, mem_we;
   logic [AB-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;

   logic f_req0 = 0, f_req1 = 0;
   logic [AB-1:0] f_addr0 = '0, f_addr1 = '0;
   logic f_gnt0, f_gnt1, f_rvalid0, f_rvalid1;
   logic [DW-1:0] f_rdata0, f_rdata1;
   logic f_mem_en, f_mem_we;
   logic [AB-1:0] f_mem_addr;
   logic [DW-1:0] f_mem_din;
   logic [DW-1:0] f_mem_dout = '0;

   mem_port_arbiter #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   mem_port_arbiter #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .req0(f_req0), .we0(1'b0), .addr0(f_addr0), .wdata0(16'h0000),
      .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
      .req1(f_req1), .we1(1'b0), .addr1(f_addr1), .wdata1(16'h0000),
      .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
      .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
      .mem_din(f_mem_din), .mem_dout(f_mem_dout)
   );

   // RAM stand-ins: registered read, read-before-write
   logic [DW-1:0] ram [0:(1<<AB)-1];
   logic [DW-1:0] shadow [0:(1<<AB)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout <= ram[mem_addr];
         if (mem_we) ram[mem_addr] <= mem_din;
      end
      if (f_mem_en) f_mem_dout <= {2'b00, f_mem_addr};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            port;
      logic [DW-1:0] data;
      int            gcyc;
   } exp_t;
   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one response per cycle, in grant order, exactly two cycles after the grant
   always @(negedge clk) begin
      if (rvalid0 || rvalid1) begin
         exp_t e;
         logic          p;
         logic [DW-1:0] d;
         p = rvalid1;
         d = rvalid1 ? rdata1 : rdata0;
         chk("rvalid_exclusive", 32'(rvalid0 && rvalid1), 32'd0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: got port %0d data %h expected no response (cycle %0d)", p, d, cyc);
         end else begin
            e = sb_q.pop_front();
            chk("resp_port", 32'(p), 32'(e.port));
            chk("resp_data", 32'(d), 32'(e.data));
            chk("resp_latency", 32'(cyc - e.gcyc), 32'd2);
            $display("resp port=%0d data=%h grant_cycle=%0d cycle=%0d", p, d, e.gcyc, cyc);
         end
      end
   end

   task automatic record(input bit port, input logic w, input logic [AB-1:0] a, input logic [DW-1:0] d);
      if (w) shadow[a] = d;
      else sb_q.push_back('{port: port, data: shadow[a], gcyc: cyc});
   endtask

   task automatic cycle_drive(input logic r0, input logic w0, input logic [AB-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic w1, input logic [AB-1:0] a1, input logic [DW-1:0] d1,
                              output logic g0, output logic g1);
      @(negedge clk);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      g0 = gnt0;
      g1 = gnt1;
      chk("gnt_exclusive", 32'(g0 && g1), 32'd0);
      if (g0) record(1'b0, w0, a0, d0);
      if (g1) record(1'b1, w1, a1, d1);
   endtask

   task automatic idle(input int n);
      logic g0, g1;
      repeat (n) cycle_drive(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
   endtask

   logic g0, g1;
   int n0, n1;
   logic p0, p1, w0r, w1r;
   logic [AB-1:0] a0r, a1r;
   logic [DW-1:0] d0r, d1r;

   initial begin
      for (int i = 0; i < (1 << AB); i++) begin
         ram[i]    = DW'(i) ^ 16'h5A5A;
         shadow[i] = DW'(i) ^ 16'h5A5A;
      end
      ram[5]    = 16'hBEEF;
      shadow[5] = 16'hBEEF;

      // Reset state, with a request held to prove grants are masked
      repeat (3) @(negedge clk);
      req0 = 1;
      req1 = 1;
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      chk("rst_rdata0", 32'(rdata0), 32'd0);
      chk("rst_rdata1", 32'(rdata1), 32'd0);
      req0 = 0;
      req1 = 0;
      @(negedge clk);
      reset_n = 1;

      // Single read by requester 0
      cycle_drive(1, 0, 14'h0005, '0, 0, 0, '0, '0, g0, g1);
      chk("t1_gnt0", 32'(g0), 32'd1);
      chk("t1_gnt1", 32'(g1), 32'd0);
      idle(1);
      chk("t1_mem_en", 32'(mem_en), 32'd1);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      chk("t1_mem_addr", 32'(mem_addr), 32'h0005);
      idle(1);
      chk("t1_rvalid0", 32'(rvalid0), 32'd1);
      chk("t1_rdata0", 32'(rdata0), 32'hBEEF);
      chk("t1_rvalid1", 32'(rvalid1), 32'd0);
      $display("txn t1 read0 addr=0005 rdata0=%h", rdata0);

      // A lone requester 1 read leaves the pointer at 1
      cycle_drive(0, 0, '0, '0, 1, 0, 14'h0020, '0, g0, g1);
      chk("t1b_gnt1", 32'(g1), 32'd1);
      idle(3);

      // Both held for six cycles in round-robin mode: 0,1,0,1,0,1
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 6; k++) begin
         cycle_drive(1, 0, 14'(16'h10 + n0), '0, 1, 0, 14'(16'h20 + n1), '0, g0, g1);
         chk("rr_gnt0", 32'(g0), 32'((k % 2) == 0));
         chk("rr_gnt1", 32'(g1), 32'((k % 2) == 1));
         $display("txn rr k=%0d gnt0=%0d gnt1=%0d", k, g0, g1);
         if (g0) n0++;
         if (g1) n1++;
      end
      idle(3);

      // Fixed-priority instance: requester 0 wins every tie
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         f_req0 = 1;
         f_req1 = 1;
         f_addr0 = 14'(16'h40 + k);
         f_addr1 = 14'h0050;
         #1;
         chk("fp_gnt0", 32'(f_gnt0), 32'd1);
         chk("fp_gnt1", 32'(f_gnt1), 32'd0);
         chk("fp_rvalid1", 32'(f_rvalid1), 32'd0);
         if (k >= 2) begin
            chk("fp_rvalid0", 32'(f_rvalid0), 32'd1);
            chk("fp_rdata0", 32'(f_rdata0), 32'(16'h40 + k - 2));
         end
         $display("txn fp k=%0d gnt0=%0d gnt1=%0d", k, f_gnt0, f_gnt1);
      end
      @(negedge clk);
      f_req0 = 0;
      #1;
      chk("fp_gnt1_after_drop", 32'(f_gnt1), 32'd1);
      @(negedge clk);
      f_req1 = 0;
      #1;
      chk("fp_mem_we", 32'(f_mem_we), 32'd0);
      chk("fp_mem_addr", 32'(f_mem_addr), 32'h0050);
      chk("fp_rdata1_hold", 32'(f_rdata1), 32'd0);
      chk("fp_mem_din", 32'(f_mem_din), 32'd0);

      // Write by requester 1, then requester 0 reads the same word
      cycle_drive(0, 0, '0, '0, 1, 1, 14'h0100, 16'h1234, g0, g1);
      chk("t4_wr_gnt1", 32'(g1), 32'd1);
      cycle_drive(1, 0, 14'h0100, '0, 0, 0, '0, '0, g0, g1);
      chk("t4_rd_gnt0", 32'(g0), 32'd1);
      idle(2);
      chk("t4_rvalid0", 32'(rvalid0), 32'd1);
      chk("t4_rdata0", 32'(rdata0), 32'h1234);
      $display("txn t4 wr1 0100=1234 then rd0 rdata0=%h", rdata0);
      idle(3);

      // Reset one cycle after a read grant drops the pending response
      cycle_drive(1, 0, 14'h0007, '0, 0, 0, '0, '0, g0, g1);
      chk("t5_gnt0", 32'(g0), 32'd1);
      @(negedge clk);
      req0 = 1;
      req1 = 1;
      reset_n = 0;
      #1;
      sb_q.delete();
      chk("t5_rst_gnt0", 32'(gnt0), 32'd0);
      chk("t5_rst_gnt1", 32'(gnt1), 32'd0);
      chk("t5_rst_mem_en", 32'(mem_en), 32'd0);
      chk("t5_rst_rvalid0", 32'(rvalid0), 32'd0);
      chk("t5_rst_rdata0", 32'(rdata0), 32'd0);
      repeat (2) @(negedge clk);
      req0 = 0;
      req1 = 0;
      reset_n = 1;
      for (int k = 0; k < 3; k++) begin
         idle(1);
         chk("t5_no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      end
      cycle_drive(1, 0, 14'h0030, '0, 1, 0, 14'h0031, '0, g0, g1);
      chk("t5_tie_gnt0", 32'(g0), 32'd1);
      chk("t5_tie_gnt1", 32'(g1), 32'd0);
      $display("txn t5 first tie after reset gnt0=%0d gnt1=%0d", g0, g1);
      idle(3);

      // Random traffic over a small address window to force collisions
      p0 = 0; p1 = 0;
      w0r = 0; w1r = 0; a0r = '0; a1r = '0; d0r = '0; d1r = '0;
      for (int k = 0; k < 1000; k++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1;
            w0r = 1'($urandom_range(0, 1));
            a0r = 14'($urandom_range(0, 31));
            d0r = 16'($urandom);
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1;
            w1r = 1'($urandom_range(0, 1));
            a1r = 14'($urandom_range(0, 31));
            d1r = 16'($urandom);
         end
         cycle_drive(p0, w0r, a0r, d0r, p1, w1r, a1r, d1r, g0, g1);
         if (p0 || p1) chk("rand_any_grant", 32'(g0 || g1), 32'd1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end
      idle(4);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
